data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the MEM-stage data-memory interface: accepts one load/store request at a
//  time from the pipeline over a valid/ready handshake. Serves it from an internal 16-bit word
//  array after a programmable wait-state count. Returns read data or write completion over a
//  valid/ready response channel. busy feeds the hazard unit so MEM can stall while a request
//  is outstanding.
// PARAMETERS
//  DEPTH        256  number of 16-bit words in the array (1..32768)
//  WAIT_CYCLES  2    wait states between request accept and response (0..15)
// PORTS
//  clk          in   1   clock; all state changes on posedge
//  reset        in   1   synchronous, active-high reset
//  req_valid    in   1   request present
//  req_ready    out  1   responder can accept a request
//  req_we       in   1   1 = store, 0 = load
//  req_addr     in   16  byte address; word index = req_addr[15:1]
//  req_wdata    in   16  store data
//  resp_valid   out  1   response present
//  resp_ready   in   1   pipeline consumes response
//  resp_rdata   out  16  load data (0 for stores and errors)
//  resp_err     out  1   access misaligned or out of range
//  busy         out  1   request accepted and response not yet consumed
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1 in the first cycle after reset, resp_valid=0, resp_rdata=0,
//   resp_err=0, busy=0, wait counter=0. Array contents are not reset; they are zero at
//   simulation start.
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: req_ready=1. A request is accepted when req_valid & req_ready on a posedge.
//     On accept, latch we/addr/wdata.
//     If WAIT_CYCLES==0, go to RESP; otherwise load the counter with WAIT_CYCLES-1 and go to WAIT.
//   WAIT: req_ready=0. Decrement the counter each cycle; at counter==0, go to RESP.
//   RESP entry (the single posedge that moves into RESP):
//     - evaluate the error: err = addr[0] | (addr[15:1] >= DEPTH)
//     - store with !err: write the array at this edge
//     - load with !err: resp_rdata = array[index]
//     - load or store with err: resp_rdata = 0, no write
//   RESP: resp_valid=1. resp_rdata and resp_err hold stable until resp_valid & resp_ready
//     on a posedge; then go to IDLE and clear resp_valid, resp_err and resp_rdata.
//  Latency: accept edge to resp_valid high = WAIT_CYCLES+1 cycles.
//   Minimum request period = WAIT_CYCLES+2 cycles, with resp_ready held high.
//  req_ready is 0 in WAIT and RESP, so a new request is never accepted in the cycle a response
//   is consumed. Requests are not pipelined.
//  busy = (state != IDLE).
//  Requests in WAIT/RESP: req_valid is ignored and inputs may change freely. The latched copy
//   is used.
//  Store-then-load to the same word: the load returns the new data, because the write commits
//   before the next accept.
//  Reset mid-operation: reset in WAIT aborts and no write occurs. Reset in RESP drops the
//   response; a write already committed at RESP entry stays. Either way, state=IDLE next cycle.
//  resp_ready held low: stay in RESP indefinitely with outputs frozen.
//  WAIT_CYCLES counter width: 4 bits. Out-of-range parameters are a configuration error.
// TESTING
//  1. Reset, then store addr=0x0010 data=0xBEEF, WAIT_CYCLES=2, resp_ready=1 -> resp_valid 3
//     cycles after accept, err=0, rdata=0. Then load 0x0010 -> rdata=0xBEEF, err=0.
//  2. Load addr=0x0011 (misaligned) -> resp_err=1, rdata=0.
//     Store to addr=2*DEPTH -> resp_err=1; a later load of word 0 is unchanged.
//  3. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err are stable; req_ready=0
//     and req_valid pulses are ignored. Raise resp_ready -> IDLE next cycle.
//  4. WAIT_CYCLES=0 build: back-to-back requests with resp_ready=1 -> one response every 2
//     cycles, latency 1.
//  5. Accept a store of 0x1234 to 0x0020, assert reset during WAIT -> IDLE, busy=0, no
//     response. A later load of 0x0020 returns the prior value (0x0000).
//  6. Stores to words 0 and DEPTH-1, then reload both -> correct data at both boundaries;
//     busy tracks the FSM throughout.

Source files
------------

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data-memory port: one load/store at a time,
// served from a 16-bit word array after WAIT_CYCLES wait states.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid & ready are both 1.
  // req_ready is high only in IDLE; resp_valid is high only in RESP and the
  // response payload is frozen until it is consumed.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          WC_M1    = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0]  CNT_INIT = WC_M1[3:0];
  localparam logic [15:0] DEPTH_W  = 16'(DEPTH);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [15:0]   addr_q, wdata_q;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          accept;
  logic          enter_resp;
  logic          do_write;
  logic          eff_we;
  logic [15:0]   eff_addr, eff_wdata;
  logic          eff_err;
  logic [AW-1:0] idx;

  logic [15:0]   mem_q [DEPTH];

  // With zero wait states the RESP entry edge is also the accept edge, so the
  // live request inputs must be used instead of the not-yet-latched copy.
  always_comb begin
    eff_we    = (state_q == S_IDLE) ? req_we    : we_q;
    eff_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    eff_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    eff_err   = eff_addr[0] | ({1'b0, eff_addr[15:1]} >= DEPTH_W);
    idx       = eff_addr[AW:1];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = 16'h0000;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_resp) begin
      err_d   = eff_err;
      rdata_d = (eff_err || eff_we) ? 16'h0000 : mem_q[idx];
    end
  end

  // Reset on the RESP entry edge must suppress the write.
  assign do_write = enter_resp & eff_we & ~eff_err & ~reset;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[idx] <= eff_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a WAIT_CYCLES=2 instance for the
// directed/random sequence and a WAIT_CYCLES=0 instance for back-to-back timing.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [15:0] resp_rdata;
  logic [1:0]  dbg_state;

  logic        req_valid0, req_ready0, req_we0;
  logic [15:0] req_addr0, req_wdata0;
  logic        resp_valid0, resp_ready0, resp_err0, busy0;
  logic [15:0] resp_rdata0;
  logic [1:0]  dbg_state0;

  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference model: plain word array plus expected {err, rdata} queue.
  logic [15:0] model_mem  [DEPTH];
  logic [15:0] model_mem0 [DEPTH];
  logic [16:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
    .dbg_state(dbg_state)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0), .busy(busy0),
    .dbg_state(dbg_state0)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("%s differs from reference", tag);
    end
  endtask

  function automatic logic [16:0] model_access(input logic we, input logic [15:0] addr,
                                                input logic [15:0] wdata, input bit zero_wait);
    int  w;
    bit  err;
    w   = int'(addr) / 2;
    err = (addr % 2 != 0) || (w >= DEPTH);
    if (err) return {1'b1, 16'h0000};
    if (we) begin
      if (zero_wait) model_mem0[w] = wdata;
      else           model_mem[w]  = wdata;
      return {1'b0, 16'h0000};
    end
    return {1'b0, zero_wait ? model_mem0[w] : model_mem[w]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one full transaction on the WC instance ----------------
  task automatic transact(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input int hold);
    int          lat;
    logic [16:0] exp, snap;
    check("req_ready_idle", req_ready, 1);
    exp_q.push_back(model_access(we, addr, wdata, 1'b0));
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);
    tick();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    check("busy_after_accept", busy, 1);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      check("req_ready_wait", req_ready, 0);
      tick();
      lat++;
    end
    check("latency", lat, WC + 1);
    exp  = exp_q.pop_front();
    snap = {resp_err, resp_rdata};
    check("resp_data", snap, exp);
    check("busy_resp", busy, 1);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom);
      req_addr  = 16'($urandom);
      tick();
      check("hold_valid", resp_valid, 1);
      check("hold_data", {resp_err, resp_rdata}, snap);
      check("hold_req_ready", req_ready, 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    check("consumed_valid", resp_valid, 0);
    check("consumed_busy", busy, 0);
    check("consumed_clear", {resp_err, resp_rdata}, 17'h0);
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return {1'b0, 7'd0, 8'($urandom_range(0, DEPTH - 1)), 1'b0} >> 1;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; resp_ready = 1'b1;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 16'h0; req_wdata0 = 16'h0; resp_ready0 = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]  = 16'h0;
      model_mem0[i] = 16'h0;
    end
    repeat (3) tick();
    reset = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_err", resp_err, 0);
    check("rst_busy", busy, 0);
    check("rst0_req_ready", req_ready0, 1);
    check("rst0_busy", busy0, 0);

    // Store then load same word.
    transact(1'b1, 16'h0010, 16'hBEEF, 0);
    transact(1'b0, 16'h0010, 16'h0000, 0);

    // Fill the whole array so later loads have known contents; word 16 gets 0.
    for (int w = 0; w < DEPTH; w++)
      transact(1'b1, 16'(w * 2), (w == 16) ? 16'h0000 : 16'($urandom), 0);

    // Misaligned load, out-of-range store, word 0 unaffected.
    transact(1'b0, 16'h0011, 16'h0000, 0);
    transact(1'b1, 16'(2 * DEPTH), 16'hDEAD, 0);
    transact(1'b0, 16'h0000, 16'h0000, 0);
    transact(1'b0, 16'hFFFE, 16'h0000, 0);

    // Back-pressure: response held for 5 cycles.
    transact(1'b0, 16'h0004, 16'h0000, 5);
    transact(1'b1, 16'h0006, 16'h5A5A, 3);

    // Reset while in WAIT aborts the store.
    check("pre_abort_ready", req_ready, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
    tick();
    req_valid = 1'b0;
    check("abort_busy_wait", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_resp", resp_valid, 0);
    end
    transact(1'b0, 16'h0020, 16'h0000, 0);

    // Boundary words.
    transact(1'b1, 16'h0000, 16'hA001, 0);
    transact(1'b1, 16'((DEPTH - 1) * 2), 16'hC0DE, 0);
    transact(1'b0, 16'h0000, 16'h0000, 0);
    transact(1'b0, 16'((DEPTH - 1) * 2), 16'h0000, 0);
    transact(1'b0, 16'(DEPTH * 2), 16'h0000, 0);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      transact(1'($urandom), rand_addr(), 16'($urandom), ($urandom_range(0, 4) == 0) ? 2 : 0);

    // Zero-wait instance: req_valid held high, a response every 2 cycles.
    req_valid0  = 1'b1;
    resp_ready0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [15:0] a;
      logic        we;
      logic [16:0] exp;
      a  = (i % 2 == 0) ? rand_addr() : req_addr0;
      we = (i % 2 == 0);
      req_we0    = we;
      req_addr0  = a;
      req_wdata0 = 16'($urandom);
      check("zw_req_ready", req_ready0, 1);
      exp = model_access(we, a, req_wdata0, 1'b1);
      tick();
      req_we0   = 1'($urandom);
      req_wdata0 = 16'($urandom);
      check("zw_latency_valid", resp_valid0, 1);
      check("zw_resp_data", {resp_err0, resp_rdata0}, exp);
      tick();
      check("zw_back_idle", resp_valid0, 0);
    end
    req_valid0 = 1'b0;
    tick();
    check("zw_idle_busy", busy0, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
